// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int ceil_div(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// Combinational W-bit ripple slice; also exposes the carry into its MSB
// so the final slice can form the signed overflow flag.
module addsub_segment import addsub_pkg::*; #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .s    (s[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout = carry[W];
    assign cmsb = carry[W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full-adder cell; the building block of every ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor, one SEG-bit slice per stage, global stall.
// Define PIPELINED_ADDSUB_SAT_EN to clamp overflowed results to the signed extreme.
module pipelined_addsub import addsub_pkg::*; #(
    parameter int N   = 8,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   sum,
    output logic         overflow
);

    localparam int STAGES = ceil_div(N, SEG);
    localparam int LAST   = STAGES - 1;

    // Values entering each stage (stage 0 from the ports, later ones from registers)
    logic [N-1:0] a_stage   [STAGES];
    logic [N-1:0] b_stage   [STAGES];
    logic [N-1:0] r_stage   [STAGES];
    logic         c_stage   [STAGES];
    logic         sub_stage [STAGES];
    logic         v_stage   [STAGES];

    logic [N-1:0] r_next     [STAGES];
    logic         c_next     [STAGES];
    logic         cout_stage [STAGES];
    logic         cmsb_stage [STAGES];
    logic         ovf_next;

    logic [N-1:0] a_reg     [STAGES];
    logic [N-1:0] b_reg     [STAGES];
    logic [N-1:0] r_reg     [STAGES];
    logic         c_reg     [STAGES];
    logic         sub_reg   [STAGES];
    logic         valid_reg [STAGES];
    logic         ovf_reg;

    assign ovf_next = cout_stage[LAST] ^ cmsb_stage[LAST];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO = gi * SEG;
            localparam int W  = ((N - LO) < SEG) ? (N - LO) : SEG;
            localparam logic [N-1:0] MASK = ({N{1'b1}} >> (N - W)) << LO;

            logic [W-1:0] seg_s;
            logic [N-1:0] r_merge;

            if (gi == 0) begin : g_head
                // Subtraction is A + ~B + 1: invert B up front, carry-in supplies the +1
                assign a_stage[gi]   = a;
                assign b_stage[gi]   = b ^ {N{sub == MODE_SUB}};
                assign r_stage[gi]   = '0;
                assign c_stage[gi]   = (sub == MODE_SUB);
                assign sub_stage[gi] = sub;
                assign v_stage[gi]   = in_valid;
            end else begin : g_link
                assign a_stage[gi]   = a_reg[gi-1];
                assign b_stage[gi]   = b_reg[gi-1];
                assign r_stage[gi]   = r_reg[gi-1];
                assign c_stage[gi]   = c_reg[gi-1];
                assign sub_stage[gi] = sub_reg[gi-1];
                assign v_stage[gi]   = valid_reg[gi-1];
            end

            addsub_segment #(.W(W)) u_seg (
                .a    (a_stage[gi][LO +: W]),
                .b    (b_stage[gi][LO +: W]),
                .cin  (c_stage[gi]),
                .s    (seg_s),
                .cout (cout_stage[gi]),
                .cmsb (cmsb_stage[gi])
            );

            assign r_merge = (r_stage[gi] & ~MASK) | (N'(seg_s) << LO);

            if (gi == LAST) begin : g_tail
                // Carry register of the last stage holds sum[N]: borrow is the inverted carry
                assign c_next[gi] = cout_stage[gi] ^ sub_stage[gi];
`ifdef PIPELINED_ADDSUB_SAT_EN
                // A wrapped-negative MSB means the true result overflowed positive
                assign r_next[gi] = ovf_next ? {~r_merge[N-1], {(N-1){r_merge[N-1]}}} : r_merge;
`else
                assign r_next[gi] = r_merge;
`endif
            end else begin : g_mid
                assign c_next[gi] = cout_stage[gi];
                assign r_next[gi] = r_merge;
            end
        end
    endgenerate

    assign out_valid = valid_reg[LAST];
    assign in_ready  = out_ready || !out_valid;
    assign sum       = {c_reg[LAST], r_reg[LAST]};
    assign overflow  = ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k] <= 1'b0;
                a_reg[k]     <= '0;
                b_reg[k]     <= '0;
                r_reg[k]     <= '0;
                c_reg[k]     <= 1'b0;
                sub_reg[k]   <= 1'b0;
            end
            ovf_reg <= 1'b0;
        end else if (in_ready) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k] <= v_stage[k];
                a_reg[k]     <= a_stage[k];
                b_reg[k]     <= b_stage[k];
                r_reg[k]     <= r_next[k];
                c_reg[k]     <= c_next[k];
                sub_reg[k]   <= sub_stage[k];
            end
            ovf_reg <= ovf_next;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomised self-checking bench for pipelined_addsub (SEG=4 main, SEG=3 and SEG=8 in throughput).
module tb_pipelined_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready, sub;
    logic [7:0] a, b;
    logic       in_ready, out_valid, overflow;
    logic [8:0] sum;

    logic       v3, v8, rdy_aux;
    logic       in_ready3, out_valid3, overflow3;
    logic       in_ready8, out_valid8, overflow8;
    logic [8:0] sum3, sum8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.N(8), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .overflow(overflow)
    );

    pipelined_addsub #(.N(8), .SEG(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(in_ready3),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid3), .out_ready(rdy_aux),
        .sum(sum3), .overflow(overflow3)
    );

    pipelined_addsub #(.N(8), .SEG(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(in_ready8),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid8), .out_ready(rdy_aux),
        .sum(sum8), .overflow(overflow8)
    );

    // Reference: signed/unsigned integer arithmetic; returns {overflow, sum[8:0]}
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int ux, uy, sx, sy, ur, sr;
        logic [7:0] res;
        logic top, ov;
        ux = int'(x);
        uy = int'(y);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        if (s) begin
            ur  = ux - uy;
            top = (ux < uy);
            sr  = sx - sy;
        end else begin
            ur  = ux + uy;
            top = (ur > 255);
            sr  = sx + sy;
        end
        res = ur[7:0];
        ov  = (sr > 127) || (sr < -128);
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (ov) res = (sr > 127) ? 8'h7F : 8'h80;
`endif
        return {ov, top, res};
    endfunction

    task automatic rand_beat();
        a   = 8'($urandom_range(0, 255));
        b   = 8'($urandom_range(0, 255));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        v3 = 1'b0; v8 = 1'b0; rdy_aux = 1'b1;
        a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        total++; if (sum !== 9'h000) begin bad++; $display("FAIL reset_sum: got %h expected 000", sum); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        $display("reset: out_valid=%b sum=%h overflow=%b in_ready=%b", out_valid, sum, overflow, in_ready);
    endtask

    task automatic test_directed();
        logic [26:0] vec [5];
        logic [9:0]  exp;
        vec[0] = {8'h3C, 8'h15, 1'b0, 10'h051};
        vec[1] = {8'hFF, 8'h01, 1'b0, 10'h100};
        vec[3] = {8'h10, 8'h20, 1'b1, 10'h1F0};
`ifdef PIPELINED_ADDSUB_SAT_EN
        vec[2] = {8'h7F, 8'h01, 1'b0, 10'h27F};
        vec[4] = {8'h80, 8'h01, 1'b1, 10'h280};
`else
        vec[2] = {8'h7F, 8'h01, 1'b0, 10'h280};
        vec[4] = {8'h80, 8'h01, 1'b1, 10'h27F};
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1;
            a = vec[i][26:19]; b = vec[i][18:11]; sub = vec[i][10];
            exp = vec[i][9:0];
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir_early[%0d]: got out_valid=%b expected 0", i, out_valid); end
            @(negedge clk);
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir_valid[%0d]: got %b expected 1", i, out_valid); end
            total++; if ({overflow, sum} !== exp) begin bad++; $display("FAIL dir_result[%0d]: got ovf=%b sum=%h expected ovf=%b sum=%h", i, overflow, sum, exp[9], exp[8:0]); end
            $display("directed %0d: a=%h b=%h sub=%b -> sum=%h overflow=%b", i, vec[i][26:19], vec[i][18:11], vec[i][10], sum, overflow);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] q[$];
        logic [9:0] exp, prev_val;
        logic       prev_hold;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; prev_hold = 1'b0; prev_val = '0;
        while (got < 6 && cyc < 80) begin
            @(negedge clk);
            if (prev_hold) begin
                total++; if (out_valid !== 1'b1 || {overflow, sum} !== prev_val) begin
                    bad++; $display("FAIL bp_hold: got valid=%b val=%h expected valid=1 val=%h", out_valid, {overflow, sum}, prev_val);
                end
            end
            out_ready = (cyc % 3 == 0);
            if (sent < 6) begin in_valid = 1'b1; rand_beat(); end
            else in_valid = 1'b0;
            #1;
            total++; if (in_ready !== !(out_valid && !out_ready)) begin
                bad++; $display("FAIL bp_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++; $display("FAIL bp_extra: got sum=%h expected no beat", sum);
                end else begin
                    exp = q.pop_front();
                    total++; if ({overflow, sum} !== exp) begin bad++; $display("FAIL bp_result[%0d]: got %h expected %h", got, {overflow, sum}, exp); end
                    $display("backpressure out %0d: sum=%h overflow=%b", got, sum, overflow);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub));
                sent++;
            end
            prev_hold = out_valid && !out_ready;
            prev_val  = {overflow, sum};
            cyc++;
        end
        total++; if (got != 6) begin bad++; $display("FAIL bp_timeout: got %0d beats expected 6", got); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_dup: got out_valid=%b expected 0", out_valid); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [9:0] exp;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; rand_beat();
        @(negedge clk);
        rand_beat();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d]: got out_valid=%b expected 0", i, out_valid); end
        end
        @(negedge clk);
        in_valid = 1'b1; rand_beat();
        exp = model(a, b, sub);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_early: got %b expected 0", out_valid); end
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid: got %b expected 1", out_valid); end
        total++; if ({overflow, sum} !== exp) begin bad++; $display("FAIL mid_result: got %h expected %h", {overflow, sum}, exp); end
        $display("reset midstream: new beat sum=%h overflow=%b", sum, overflow);
    endtask

    task automatic test_back_to_back();
        logic       hv   [64];
        logic [9:0] hval [64];
        for (int i = 0; i < 64; i++) begin hv[i] = 1'b0; hval[i] = '0; end
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (i < 32) begin
                rand_beat();
                in_valid = 1'b1; v3 = 1'b1; v8 = 1'b1;
                hv[i] = 1'b1; hval[i] = model(a, b, sub);
            end else begin
                in_valid = 1'b0; v3 = 1'b0; v8 = 1'b0;
            end
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL tp_ready[%0d]: got %b expected 1", i, in_ready); end
            // SEG=4: two stages
            total++; if (out_valid !== (i >= 2 && hv[(i >= 2) ? i-2 : 0])) begin
                bad++; $display("FAIL tp4_valid[%0d]: got %b", i, out_valid);
            end else if (out_valid) begin
                total++; if ({overflow, sum} !== hval[i-2]) begin bad++; $display("FAIL tp4_result[%0d]: got %h expected %h", i, {overflow, sum}, hval[i-2]); end
                $display("tp seg4 cyc %0d: sum=%h overflow=%b", i, sum, overflow);
            end
            // SEG=3: three stages, last one two bits wide
            total++; if (out_valid3 !== (i >= 3 && hv[(i >= 3) ? i-3 : 0])) begin
                bad++; $display("FAIL tp3_valid[%0d]: got %b", i, out_valid3);
            end else if (out_valid3) begin
                total++; if ({overflow3, sum3} !== hval[i-3]) begin bad++; $display("FAIL tp3_result[%0d]: got %h expected %h", i, {overflow3, sum3}, hval[i-3]); end
                $display("tp seg3 cyc %0d: sum=%h overflow=%b", i, sum3, overflow3);
            end
            // SEG=8: single stage
            total++; if (out_valid8 !== (i >= 1 && hv[(i >= 1) ? i-1 : 0])) begin
                bad++; $display("FAIL tp8_valid[%0d]: got %b", i, out_valid8);
            end else if (out_valid8) begin
                total++; if ({overflow8, sum8} !== hval[i-1]) begin bad++; $display("FAIL tp8_result[%0d]: got %h expected %h", i, {overflow8, sum8}, hval[i-1]); end
                $display("tp seg8 cyc %0d: sum=%h overflow=%b", i, sum8, overflow8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
